// File: rtl/dispatch_pkg.sv
// Shared dispatch types: reservation-station classes, RV opcode fields and helpers.
package dispatch_pkg;

  localparam int unsigned NUM_RS = 4;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F7_W   = 7;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    MUL = 2'd1,
    LSU = 2'd2,
    BR  = 2'd3
  } rs_class_t;

  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [F7_W-1:0]  F7_MULDIV = 7'b0000001;

  // One-hot station select for a class code.
  function automatic logic [NUM_RS-1:0] rs_onehot(input rs_class_t cls);
    return NUM_RS'(1) << cls;
  endfunction

endpackage

// File: rtl/iq_dispatch_if.sv
// Queue-read, reservation-station and dispatch-register signals of iq_dispatch.
interface iq_dispatch_if #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH = 5
);

  logic                              iq_empty;
  logic [D_WIDTH-1:0]                iq_rdata;
  logic                              iq_ren;
  logic [dispatch_pkg::NUM_RS-1:0]   rs_ready;
  logic [dispatch_pkg::NUM_RS-1:0]   rs_we;
  logic                              disp_valid;
  dispatch_pkg::rs_class_t           disp_class;
  logic [D_WIDTH-1:0]                disp_inst;
  logic [TAG_WIDTH-1:0]              disp_tag;

  modport master (
    input  iq_empty, iq_rdata, rs_ready,
    output iq_ren, rs_we, disp_valid, disp_class, disp_inst, disp_tag
  );

  modport slave (
    output iq_empty, iq_rdata, rs_ready,
    input  iq_ren, rs_we, disp_valid, disp_class, disp_inst, disp_tag
  );

endinterface

// File: rtl/inst_classify.sv
// Combinational instruction-word to reservation-station class decoder.
module inst_classify
  import dispatch_pkg::*;
(
  input  logic [31:0] word,
  output rs_class_t   cls
);

  logic [OPC_W-1:0] opcode;
  logic [F7_W-1:0]  funct7;
  logic             unused_bits;

  assign opcode      = word[6:0];
  assign funct7      = word[31:25];
  assign unused_bits = ^word[24:7];

  // Illegal encodings fall through to ALU, which owns the exception.
  always_comb begin
    cls = ALU;
    case (opcode)
      OP_REG:                     cls = (funct7 == F7_MULDIV) ? MUL : ALU;
      OP_LOAD, OP_STORE:          cls = LSU;
      OP_BRANCH, OP_JAL, OP_JALR: cls = BR;
      default:                    cls = ALU;
    endcase
  end

endmodule

// File: rtl/iq_dispatch.sv
// Instruction-queue consumer: pops show-ahead head, holds one word, writes it to its station.
module iq_dispatch
  import dispatch_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  iq_dispatch_if.master bus
);

  logic                 valid_q;
  logic [D_WIDTH-1:0]   inst_q;
  rs_class_t            cls_q;
  logic [TAG_WIDTH-1:0] tag_q;

  rs_class_t            cls_d;
  logic                 fire;
  logic                 pop;

  inst_classify u_classify (
    .word (bus.iq_rdata[31:0]),
    .cls  (cls_d)
  );

  // rst gates both strobes so a held word is dropped silently.
  assign fire = ~rst & ~flush & valid_q & bus.rs_ready[cls_q];
  assign pop  = ~rst & ~flush & ~bus.iq_empty & (~valid_q | fire);

  assign bus.iq_ren     = pop;
  assign bus.rs_we      = fire ? rs_onehot(cls_q) : '0;
  assign bus.disp_valid = valid_q;
  assign bus.disp_class = cls_q;
  assign bus.disp_inst  = inst_q;
  assign bus.disp_tag   = tag_q;

  // Output register: pop replaces, fire alone empties, flush drops without touching the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      cls_q   <= ALU;
      tag_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (pop) begin
        valid_q <= 1'b1;
        inst_q  <= bus.iq_rdata;
        cls_q   <= cls_d;
      end else if (fire) begin
        valid_q <= 1'b0;
      end
      if (fire) begin
        tag_q <= tag_q + TAG_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_iq_dispatch.sv
// Scoreboard bench for iq_dispatch with a behavioural show-ahead queue.
module tb_iq_dispatch;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  cls;
  } ent_t;

  logic clk;
  logic rst;
  logic flush;

  iq_dispatch_if #(.D_WIDTH(32), .TAG_WIDTH(5)) bus ();

  iq_dispatch #(.D_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ent_t        q_mem[$];
  ent_t        sb[$];
  logic [4:0]  mtag;
  logic [4:0]  fire_tags[$];
  int          ren_cnt;
  int          n_checks;
  int          n_errors;
  logic [31:0] tbl_word[10];
  logic [1:0]  tbl_cls[10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_q();
    bus.iq_empty = (q_mem.size() == 0);
    if (q_mem.size() != 0) bus.iq_rdata = q_mem[0].word;
    else bus.iq_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic push(input int idx);
    ent_t e;
    e.word = tbl_word[idx];
    e.cls  = tbl_cls[idx];
    q_mem.push_back(e);
    drive_q();
  endtask

  task automatic chk_reset_state();
    #1;
    chk("rst_valid", 32'(bus.disp_valid), 32'd0);
    chk("rst_inst",  bus.disp_inst, 32'd0);
    chk("rst_class", 32'(bus.disp_class), 32'd0);
    chk("rst_tag",   32'(bus.disp_tag), 32'd0);
  endtask

  // One cycle: compare against the model, advance the model, then advance the queue.
  task automatic tick();
    ent_t       h;
    logic       efire;
    logic       eren;
    logic [3:0] ewe;
    logic       ren_seen;
    #1;
    efire = 1'b0;
    h.word = '0;
    h.cls  = '0;
    if (sb.size() != 0) begin
      h = sb[0];
      efire = bus.rs_ready[h.cls] && !flush && !rst;
    end
    eren = !rst && !flush && (q_mem.size() != 0) && ((sb.size() == 0) || efire);
    ewe  = efire ? (4'b0001 << h.cls) : 4'b0000;
    chk("iq_ren", 32'(bus.iq_ren), 32'(eren));
    chk("rs_we", 32'(bus.rs_we), 32'(ewe));
    chk("disp_valid", 32'(bus.disp_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("disp_inst", bus.disp_inst, h.word);
      chk("disp_class", 32'(bus.disp_class), 32'(h.cls));
      chk("disp_tag", 32'(bus.disp_tag), 32'(mtag));
    end
    if (bus.iq_ren) ren_cnt++;
    if (bus.rs_we != 4'b0000) fire_tags.push_back(bus.disp_tag);
    ren_seen = bus.iq_ren;
    if (rst) begin
      sb.delete();
      mtag = '0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (efire) begin
        void'(sb.pop_front());
        mtag = mtag + 5'd1;
      end
      if (eren) sb.push_back(q_mem[0]);
    end
    @(posedge clk);
    @(negedge clk);
    if (ren_seen && q_mem.size() != 0) void'(q_mem.pop_front());
    drive_q();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tbl_word[0] = 32'h00B50533; tbl_cls[0] = 2'd0;  // add
    tbl_word[1] = 32'h02B50533; tbl_cls[1] = 2'd1;  // mul
    tbl_word[2] = 32'h0005A503; tbl_cls[2] = 2'd2;  // lw
    tbl_word[3] = 32'h00B50463; tbl_cls[3] = 2'd3;  // beq
    tbl_word[4] = 32'h00B52023; tbl_cls[4] = 2'd2;  // sw
    tbl_word[5] = 32'h008000EF; tbl_cls[5] = 2'd3;  // jal
    tbl_word[6] = 32'h000080E7; tbl_cls[6] = 2'd3;  // jalr
    tbl_word[7] = 32'h02B54533; tbl_cls[7] = 2'd1;  // div
    tbl_word[8] = 32'h40B50533; tbl_cls[8] = 2'd0;  // sub
    tbl_word[9] = 32'hFFFFFFFF; tbl_cls[9] = 2'd0;  // illegal

    clk = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    bus.rs_ready = 4'hF;
    mtag = '0;
    ren_cnt = 0;
    n_checks = 0;
    n_errors = 0;
    drive_q();
    @(negedge clk);
    ticks(2);
    rst = 1'b0;
    chk_reset_state();

    // Back-to-back stream, all stations ready.
    for (int i = 0; i < 4; i++) push(i);
    ren_cnt = 0;
    fire_tags.delete();
    ticks(6);
    chk("b2b_ren_cnt", 32'(ren_cnt), 32'd4);
    chk("b2b_fires", 32'(fire_tags.size()), 32'd4);
    if (fire_tags.size() == 4) chk("b2b_last_tag", 32'(fire_tags[3]), 32'd3);

    // Stall on MUL with a second word waiting behind it.
    bus.rs_ready = 4'b1101;
    push(1);
    tick();
    push(0);
    ticks(5);
    bus.rs_ready = 4'hF;
    ticks(3);

    // Empty queue, then one word.
    ren_cnt = 0;
    ticks(5);
    chk("empty_ren_cnt", 32'(ren_cnt), 32'd0);
    push(5);
    ticks(3);

    // Flush during an LSU stall; next word reuses the tag.
    bus.rs_ready = 4'b1011;
    push(2);
    push(8);
    ticks(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    bus.rs_ready = 4'hF;
    ticks(3);

    // Tag wrap over 33 dispatches from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state();
    fire_tags.delete();
    for (int i = 0; i < 33; i++) push(i % 10);
    ticks(36);
    chk("wrap_fires", 32'(fire_tags.size()), 32'd33);
    if (fire_tags.size() == 33) begin
      chk("wrap_first", 32'(fire_tags[0]), 32'd0);
      chk("wrap_31", 32'(fire_tags[31]), 32'd31);
      chk("wrap_32", 32'(fire_tags[32]), 32'd0);
    end

    // Reset while holding a stalled word.
    bus.rs_ready = 4'b0000;
    push(6);
    push(4);
    ticks(2);
    bus.rs_ready = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state();
    ticks(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
